// File: rtl/switch_debounce.sv
// Switch front end: two-flop synchroniser, per-channel consecutive-sample debounce FSM,
// registered clean levels with single-cycle rise/fall strobes.
module switch_debounce #(
  parameter int unsigned N_SW            = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 120000,
  parameter bit          RESET_LEVEL     = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_SW-1:0] sw_raw,
  output logic [N_SW-1:0] sw_level,
  output logic [N_SW-1:0] sw_rise,
  output logic [N_SW-1:0] sw_fall,
  output logic [N_SW-1:0] sw_busy
);

  localparam int unsigned   CntW    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  typedef enum logic {StStable, StCheck} state_e;

  logic [N_SW-1:0] sync1_q, sync2_q;
  logic [N_SW-1:0] level_q, level_d;
  logic [N_SW-1:0] rise_q, rise_d;
  logic [N_SW-1:0] fall_q, fall_d;
  state_e          state_q [N_SW];
  state_e          state_d [N_SW];
  logic [CntW-1:0] cnt_q [N_SW];
  logic [CntW-1:0] cnt_d [N_SW];

  // State register: synchroniser, FSM state, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= {N_SW{RESET_LEVEL}};
      sync2_q <= {N_SW{RESET_LEVEL}};
      level_q <= {N_SW{RESET_LEVEL}};
      rise_q  <= '0;
      fall_q  <= '0;
      for (int i = 0; i < N_SW; i++) begin
        state_q[i] <= StStable;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q <= sw_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: a change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < N_SW; i++) begin
      unique case (state_q[i])
        StStable: begin
          if (sync2_q[i] != level_q[i]) begin
            state_d[i] = StCheck;
            cnt_d[i]   = CntOne;
          end else begin
            cnt_d[i] = '0;
          end
        end
        StCheck: begin
          if (sync2_q[i] == level_q[i]) begin
            state_d[i] = StStable;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CntLast) begin
            state_d[i] = StStable;
            cnt_d[i]   = '0;
            level_d[i] = sync2_q[i];
            rise_d[i]  = sync2_q[i];
            fall_d[i]  = ~sync2_q[i];
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
      endcase
    end
  end

  // Outputs: all taken straight from flops.
  always_comb begin
    sw_level = level_q;
    sw_rise  = rise_q;
    sw_fall  = fall_q;
    sw_busy  = '0;
    for (int i = 0; i < N_SW; i++) begin
      sw_busy[i] = (state_q[i] == StCheck);
    end
  end

endmodule
